alu_seq_muldiv: RTL and testbench

- Sequential successor to the single-cycle combinational ALU, parametrised in data width.
- Adds registered results, a valid/ready handshake on both sides, and iterative RV32M multiply/divide/remainder alongside all base ALU operations.
- Sits in the execute stage. The pipeline stalls on in_ready low or out_valid pending.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_muldiv_iter.sv | 82 ++++++++
 rtl/alu_seq_muldiv.sv | 110 +++++++++++
 tb/tb_alu_seq_muldiv.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and opcode classification for the
// sequential ALU with iterative RV32M multiply/divide.
package alu_pkg;

   localparam int OP_W = 5;

   typedef enum logic [OP_W-1:0] {
      OP_AND    = 5'b00000,
      OP_OR     = 5'b00001,
      OP_ADD    = 5'b00010,
      OP_SLL    = 5'b00100,
      OP_SRL    = 5'b00101,
      OP_SUB    = 5'b00110,
      OP_SRA    = 5'b00111,
      OP_EQ     = 5'b01000,
      OP_MUL    = 5'b10000,
      OP_MULH   = 5'b10001,
      OP_MULHU  = 5'b10010,
      OP_MULHSU = 5'b10011,
      OP_DIV    = 5'b10100,
      OP_DIVU   = 5'b10101,
      OP_REM    = 5'b10110,
      OP_REMU   = 5'b10111
   } alu_op_e;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} alu_state_e;

   // Within the M group, bit 2 selects divide-class, bit 1 remainder, bit 0 unsigned
   function automatic logic is_muldiv(input logic [OP_W-1:0] op);
      return op[4:3] == 2'b10;
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes,
// one bit per cycle, with sign fix-up folded into the final iteration.
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [OP_W-1:0]       op,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH);

   logic            run;
   logic [CW-1:0]   cnt;
   logic [2*W-1:0]  acc, acc_nx, prod;
   logic [W-1:0]    opnd, ma, mb, q, r;
   logic            is_div, neg_q, neg_r, a_sgn, b_sgn;
   logic [1:0]      sel;
   logic [W:0]      sum, r_sh, diff;

   always_comb begin
      a_sgn = a[W-1] && (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
      b_sgn = b[W-1] && (op == OP_MULH || op == OP_DIV || op == OP_REM);
      ma    = a_sgn ? -a : a;
      mb    = b_sgn ? -b : b;
   end

   // acc holds {hi, multiplier} when multiplying and {remainder, quotient} when dividing
   always_comb begin
      sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
      r_sh = acc[2*W-1:W-1];
      diff = r_sh - {1'b0, opnd};
      if (is_div)
         acc_nx = diff[W] ? {acc[2*W-2:0], 1'b0} : {diff[W-1:0], acc[W-2:0], 1'b1};
      else
         acc_nx = {sum, acc[W-1:1]};
      prod = neg_q ? -acc_nx : acc_nx;
      q    = neg_q ? -acc_nx[W-1:0] : acc_nx[W-1:0];
      r    = neg_r ? -acc_nx[2*W-1:W] : acc_nx[2*W-1:W];
      if (is_div)
         result = sel[1] ? r : q;
      else
         result = (sel == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
   end

   assign done = run && (&cnt);

   always_ff @(posedge clk) begin
      if (reset) begin
         run    <= 1'b0;
         cnt    <= '0;
         acc    <= '0;
         opnd   <= '0;
         is_div <= 1'b0;
         sel    <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
      end else if (start) begin
         run    <= 1'b1;
         cnt    <= '0;
         is_div <= op[2];
         sel    <= op[1:0];
         neg_q  <= a_sgn ^ b_sgn;
         neg_r  <= a_sgn;
         opnd   <= op[2] ? mb : ma;
         acc    <= op[2] ? {{W{1'b0}}, ma} : {{W{1'b0}}, mb};
      end else if (run) begin
         acc <= acc_nx;
         cnt <= cnt + 1'b1;
         if (&cnt) run <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_seq_muldiv.sv
// Registered execute-stage ALU with valid/ready handshakes; base ops and
// divide special cases finish in one cycle, multiply/divide iterate.
module alu_seq_muldiv
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 5,
   parameter int SHAMT_WIDTH   = $clog2(DATA_WIDTH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_WIDTH-1:0]    SrcA,
   input  logic [DATA_WIDTH-1:0]    SrcB,
   input  logic [OPCODE_LENGTH-1:0] Operation,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH-1:0]    ALUResult,
   output logic                     busy
);

   localparam int W = DATA_WIDTH;
   localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

   alu_state_e          state;
   logic [OP_W-1:0]     op;
   logic [SHAMT_WIDTH-1:0] shamt;
   logic [W-1:0]        base_res, fast_res, iter_res;
   logic                fast, accept, start, iter_done;

   assign op     = Operation;
   assign shamt  = SrcB[SHAMT_WIDTH-1:0];
   assign accept = in_ready && in_valid;
   assign start  = accept && is_muldiv(op) && !fast;

   always_comb begin
      case (op)
         OP_AND:  base_res = SrcA & SrcB;
         OP_OR:   base_res = SrcA | SrcB;
         OP_ADD:  base_res = SrcA + SrcB;
         OP_SUB:  base_res = SrcA - SrcB;
         OP_SLL:  base_res = SrcA << shamt;
         OP_SRL:  base_res = SrcA >> shamt;
         OP_SRA:  base_res = $signed(SrcA) >>> shamt;
         OP_EQ:   base_res = {{(W-1){1'b0}}, SrcA == SrcB};
         default: base_res = '0;
      endcase
      // Divide by zero and signed overflow bypass the iterative datapath
      fast = is_muldiv(op) && op[2] &&
             ((SrcB == '0) || (!op[0] && SrcA == MOST_NEG && SrcB == '1));
      if (SrcB == '0)
         fast_res = op[1] ? SrcA : '1;
      else
         fast_res = op[1] ? '0 : SrcA;
   end

   alu_muldiv_iter #(.DATA_WIDTH(DATA_WIDTH)) u_iter (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .a      (SrcA),
      .b      (SrcB),
      .done   (iter_done),
      .result (iter_res)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         ALUResult <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               in_ready <= 1'b0;
               if (start) begin
                  state <= BUSY;
                  busy  <= 1'b1;
               end else begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  ALUResult <= fast ? fast_res : base_res;
               end
            end
            BUSY: if (iter_done) begin
               state     <= DONE;
               busy      <= 1'b0;
               out_valid <= 1'b1;
               ALUResult <= iter_res;
            end
            DONE: if (out_ready) begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Bench for alu_seq_muldiv: directed cases plus random traffic, all checked
// each cycle against a transaction-level arithmetic model.
module tb_alu_seq_muldiv;

   localparam int W = 32;

   logic          clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
   logic          in_ready, out_valid, busy;
   logic [W-1:0]  SrcA = '0, SrcB = '0, ALUResult;
   logic [4:0]    Operation = '0;

   int errors = 0, checks = 0;

   always #5 clk = ~clk;

   alu_seq_muldiv dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .SrcA      (SrcA),
      .SrcB      (SrcB),
      .Operation (Operation),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ALUResult (ALUResult),
      .busy      (busy)
   );

   function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'h0, a});
      ub = longint'({32'h0, b});
      p  = '0;
      case (op)
         5'b00000: p[31:0] = a & b;
         5'b00001: p[31:0] = a | b;
         5'b00010: p[31:0] = a + b;
         5'b00110: p[31:0] = a - b;
         5'b00100: p[31:0] = a << b[4:0];
         5'b00101: p[31:0] = a >> b[4:0];
         5'b00111: p = sa >>> b[4:0];
         5'b01000: p[0] = (a == b);
         5'b10000: p = ua * ub;
         5'b10001: p = (sa * sb) >> 32;
         5'b10010: p = (ua * ub) >> 32;
         5'b10011: p = (sa * ub) >> 32;
         5'b10100: if (b == 0) p = '1; else if (a == 32'h80000000 && b == 32'hFFFFFFFF) p[31:0] = a; else p = sa / sb;
         5'b10101: if (b == 0) p = '1; else p = ua / ub;
         5'b10110: if (b == 0) p[31:0] = a; else if (a == 32'h80000000 && b == 32'hFFFFFFFF) p = '0; else p = sa % sb;
         5'b10111: if (b == 0) p[31:0] = a; else p = ua % ub;
         default:  p = '0;
      endcase
      return p[31:0];
   endfunction

   function automatic int lat_of(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      bit special;
      special = op[2] && ((b == 0) || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
      return (op[4:3] == 2'b10 && !special) ? W + 1 : 1;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Transaction model: one outstanding request, result visible at accept+latency
   int          cyc = 0, m_ready = 0;
   bit          started = 0, m_pend = 0;
   logic [31:0] m_res = '0, m_last = '0;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      started <= 1'b1;
      if (reset) begin
         m_pend <= 1'b0;
         m_last <= '0;
      end else if (!m_pend) begin
         if (in_valid) begin
            m_pend  <= 1'b1;
            m_res   <= model(Operation, SrcA, SrcB);
            m_ready <= cyc + lat_of(Operation, SrcA, SrcB);
         end
      end else if (cyc >= m_ready && out_ready) begin
         m_pend <= 1'b0;
         m_last <= m_res;
      end
   end

   always @(negedge clk) begin
      if (started)
         check("cycle {in_ready,busy,out_valid,ALUResult}",
               {in_ready, busy, out_valid, ALUResult},
               {!m_pend, m_pend && (cyc < m_ready), m_pend && (cyc >= m_ready),
                (m_pend && cyc >= m_ready) ? m_res : m_last});
   end

   task automatic req(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] res, output int lat);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin @(negedge clk); n++; end
      Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      SrcA = $urandom; SrcB = $urandom; Operation = 5'($urandom);
      lat = 1;
      while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
      res = ALUResult;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'($urandom_range(0, 9));
         default: return $urandom;
      endcase
   endfunction

   typedef struct {logic [4:0] op; logic [31:0] a, b, exp; int lat;} vec_t;
   vec_t vt[14];
   logic [4:0] ops[20];

   initial begin
      logic [31:0] res;
      int lat;

      check("pin_mulhsu", model(5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF);
      check("pin_mulhu",  model(5'b10010, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFE);
      check("pin_rem_pos_neg", model(5'b10110, 32'd7, 32'hFFFFFFFE), 32'h1);
      check("pin_srl",    model(5'b00101, 32'h80000000, 32'h3F), 32'h1);

      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Reset in the middle of an iterative DIVU
      Operation = 5'b10101; SrcA = 32'd100; SrcB = 32'd7; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("t1_busy_before_reset", busy, 1);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("t1_in_ready", in_ready, 1);
      check("t1_out_valid", out_valid, 0);
      check("t1_result", ALUResult, 0);
      repeat (40) @(negedge clk);

      vt[0]  = '{5'b00010, 32'hFFFFFFFF, 32'h1,        32'h0,        1};
      vt[1]  = '{5'b00111, 32'h80000000, 32'h24,       32'hF8000000, 1};
      vt[2]  = '{5'b10001, 32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 33};
      vt[3]  = '{5'b10000, 32'hFFFFFFFE, 32'h3,        32'hFFFFFFFA, 33};
      vt[4]  = '{5'b10100, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 33};
      vt[5]  = '{5'b10110, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 33};
      vt[6]  = '{5'b10101, 32'h7,        32'h0,        32'hFFFFFFFF, 1};
      vt[7]  = '{5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
      vt[8]  = '{5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1};
      vt[9]  = '{5'b10111, 32'h5,        32'h0,        32'h5,        1};
      vt[10] = '{5'b01000, 32'h1234,     32'h1234,     32'h1,        1};
      vt[11] = '{5'b11000, 32'h5,        32'h3,        32'h0,        1};
      vt[12] = '{5'b10010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
      vt[13] = '{5'b00110, 32'h0,        32'h1,        32'hFFFFFFFF, 1};
      for (int i = 0; i < 14; i++) begin
         req(vt[i].op, vt[i].a, vt[i].b, res, lat);
         check($sformatf("vec%0d_result", i), res, vt[i].exp);
         check($sformatf("vec%0d_latency", i), lat, vt[i].lat);
      end
      @(negedge clk);
      check("t2_in_ready_after_handshake", in_ready, 1);

      // Result held under back-pressure; new request waits for IDLE
      out_ready = 1'b0;
      Operation = 5'b00010; SrcA = 32'd1; SrcB = 32'd2; in_valid = 1'b1;
      @(negedge clk);
      Operation = 5'b00110; SrcA = 32'd10; SrcB = 32'd3;
      lat = 0;
      while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t6_held_result", ALUResult, 32'd3);
         check("t6_in_ready_low", in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("t6_in_ready_rises", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      check("t6_new_valid", out_valid, 1);
      check("t6_new_result", ALUResult, 32'd7);

      ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00110, 5'b00100, 5'b00101, 5'b00111,
              5'b01000, 5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10100, 5'b10101,
              5'b10110, 5'b10111, 5'b00011, 5'b01111, 5'b11010, 5'b10100};
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         reset     = ($urandom_range(0, 299) == 0);
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         Operation = ops[$urandom_range(0, 19)];
         SrcA      = pick();
         SrcB      = pick();
      end
      @(negedge clk);
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (40) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
